serial_subtractor: RTL and testbench

Bit-serial N-bit unsigned subtractor built around the one-bit full-subtractor cell (ports X, Y, BIN, DIFF, B_OUT). It sits directly upstream of that cell. Each cycle it presents one operand bit pair and the registered borrow to the cell, then captures the cell's DIFF and B_OUT. It trades latency for area: one full-subtractor instance plus shift registers replaces a WIDTH-bit ripple chain. A start/done handshake frames each operation, and the chainable borrow-in/borrow-out supports multi-word subtraction.

---
 rtl/serial_subtractor.sv | 143 ++++++++++++++
 tb/tb_serial_subtractor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB-first operand
// shift registers, a borrow flop and a result shift register. start/done frame
// each operation. bin/borrow chain words together for wider subtractions.

// One-bit full subtractor: DIFF = X - Y - BIN, B_OUT set when that underflows.
module full_subtractor (
  input  logic X,
  input  logic Y,
  input  logic BIN,
  output logic DIFF,
  output logic B_OUT
);
  assign DIFF  = X ^ Y ^ BIN;
  assign B_OUT = (~X & (Y | BIN)) | (Y & BIN);
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               bflop_q, bflop_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_q, borrow_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               cell_diff_s;
  logic               cell_bout_s;
  logic [WIDTH-1:0]   res_shift_s;

  full_subtractor u_cell (
    .X     (a_sr_q[0]),
    .Y     (b_sr_q[0]),
    .BIN   (bflop_q),
    .DIFF  (cell_diff_s),
    .B_OUT (cell_bout_s)
  );

  // Result register shifted right with the new DIFF bit entering at the MSB.
  assign res_shift_s = {cell_diff_s, {(WIDTH-1){1'b0}}} | (res_q >> 1);

  // Next-state and datapath control; every register holds unless changed.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_d    = res_q;
    bflop_d  = bflop_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SHIFT;
          a_sr_d  = a;
          b_sr_d  = b;
          bflop_d = bin;
          cnt_d   = {CNT_W{1'b0}};
          res_d   = {WIDTH{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        res_d   = res_shift_s;
        bflop_d = cell_bout_s;
        if (cnt_q == LAST_BIT) begin
          state_d  = S_DONE;
          diff_d   = res_shift_s;
          borrow_d = cell_bout_s;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Status flags are registered copies of the state being entered.
    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      a_sr_q   <= {WIDTH{1'b0}};
      b_sr_q   <= {WIDTH{1'b0}};
      res_q    <= {WIDTH{1'b0}};
      bflop_q  <= 1'b0;
      diff_q   <= {WIDTH{1'b0}};
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_q    <= res_d;
      bflop_q  <= bflop_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: an 8-bit instance driven from a
// vector table and hand-written corner sequences, and a 3-bit instance swept
// exhaustively. Expected {borrow, diff} go into per-instance queues at accept
// time and are popped by a monitor whenever done pulses.
module tb_serial_subtractor;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start8, bin8, busy8, done8, borrow8;
  logic [7:0] a8, b8, diff8;
  logic       start3, bin3, busy3, done3, borrow3;
  logic [2:0] a3, b3, diff3;

  int tests_run = 0;
  int tests_failed = 0;

  logic [8:0] q8[$];
  logic [3:0] q3[$];

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
  );

  serial_subtractor #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .bin(bin3),
    .busy(busy3), .done(done3), .diff(diff3), .borrow(borrow3)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       borrow;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [8:0] e8;
    logic [3:0] e3;
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        check("dut8_unexpected_done", 32'd1, 32'd0);
      end else begin
        e8 = q8.pop_front();
        check("dut8_result", 32'({borrow8, diff8}), 32'(e8));
      end
    end
    if (done3 === 1'b1) begin
      if (q3.size() == 0) begin
        check("dut3_unexpected_done", 32'd1, 32'd0);
      end else begin
        e3 = q3.pop_front();
        check("dut3_result", 32'({borrow3, diff3}), 32'(e3));
      end
    end
  end

  function automatic logic get_done(input bit w3);
    return w3 ? done3 : done8;
  endfunction

  function automatic logic get_busy(input bit w3);
    return w3 ? busy3 : busy8;
  endfunction

  // Count negedges until done is seen; bounded so a missing done still ends.
  task automatic wait_done(input bit w3, inout int cyc);
    while (cyc < 40 && get_done(w3) !== 1'b1) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // One full operation: accept, check busy, latency, single-cycle done.
  task automatic run_op(input bit w3, input logic [7:0] av, input logic [7:0] bv,
                        input logic bi, input logic [7:0] ed, input logic eb);
    int cyc;
    @(negedge clk);
    if (w3) begin
      a3 = av[2:0]; b3 = bv[2:0]; bin3 = bi; start3 = 1'b1;
      q3.push_back({eb, ed[2:0]});
    end else begin
      a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1;
      q8.push_back({eb, ed});
    end
    @(negedge clk);
    start3 = 1'b0;
    start8 = 1'b0;
    check("busy_after_accept", 32'(get_busy(w3)), 32'd1);
    cyc = 0;
    wait_done(w3, cyc);
    check("done_latency", 32'(cyc), w3 ? 32'd3 : 32'd8);
    check("busy_low_at_done", 32'(get_busy(w3)), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(get_done(w3)), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    int cyc;
    bit saw_done;
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
    vecs[4] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
    vecs[5] = '{8'h12, 8'h34, 1'b0, 8'hDE, 1'b1};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

    rst_n = 1'b0;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
    start3 = 1'b0; a3 = 3'd0;  b3 = 3'd0;  bin3 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy8), 32'd0);
    check("reset_done", 32'(done8), 32'd0);
    check("reset_diff", 32'(diff8), 32'd0);
    check("reset_borrow", 32'(borrow8), 32'd0);
    rst_n = 1'b1;

    // Table-driven 8-bit vectors.
    for (int i = 0; i < 7; i++) begin
      run_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].borrow);
    end

    // Start during SHIFT is ignored; then back-to-back accept in DONE.
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    q8.push_back({1'b0, 8'h0F});
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("ignored_start_busy", 32'(busy8), 32'd1);
    check("ignored_start_diff_held", 32'(diff8), 32'hFF);
    cyc = 3;
    wait_done(1'b0, cyc);
    check("overlap_latency", 32'(cyc), 32'd8);
    a8 = 8'h03; b8 = 8'h05; bin8 = 1'b0; start8 = 1'b1;
    q8.push_back({1'b1, 8'hFE});
    @(negedge clk);
    start8 = 1'b0;
    check("b2b_no_gap_busy", 32'(busy8), 32'd1);
    check("b2b_no_gap_done", 32'(done8), 32'd0);
    cyc = 0;
    wait_done(1'b0, cyc);
    check("b2b_latency", 32'(cyc), 32'd8);
    @(negedge clk);

    // Reset at cycle 4 of SHIFT aborts the operation with no done.
    a8 = 8'h77; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_diff", 32'(diff8), 32'd0);
    check("abort_borrow", 32'(borrow8), 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 === 1'b1) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    run_op(1'b0, 8'h77, 8'h11, 1'b0, 8'h66, 1'b0);

    // Exhaustive 3-bit sweep against an integer reference.
    for (int ia = 0; ia < 8; ia++) begin
      for (int ib = 0; ib < 8; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          int r;
          r = ia - ib - ic;
          run_op(1'b1, 8'(ia), 8'(ib), 1'(ic), 8'(r & 7), (r < 0) ? 1'b1 : 1'b0);
        end
      end
    end

    repeat (2) @(negedge clk);
    check("q8_drained", 32'(q8.size()), 32'd0);
    check("q3_drained", 32'(q3.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
